mux_alu_core: RTL and testbench
===============================

Name: mux_alu_core

Overview:
- Pipelined 4-operand ALU/mux that sits on the receiving end of the team's mux/ALU stimulus interface.
- Accepts operands A, B, C, D and opcode sel through a valid/ready handshake.
- Computes a 33-bit result, which includes a carry/borrow bit and a running accumulator.
- Returns the result through a valid/ready output channel with full backpressure support.

Parameters:
- DW, 32, operand width; result width is DW+1.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  DW  operand A.
- B  input  DW  operand B.
- C  input  DW  operand C.
- D  input  DW  operand D.
- sel  input  3  opcode.
- in_valid  input  1  operands and sel are valid this cycle.
- in_ready  output  1  block can accept a transaction this cycle.
- out  output  DW+1  result.
- out_sel  output  3  opcode that produced out.
- out_valid  output  1  out and out_sel are valid.
- out_ready  input  1  sink accepts the result this cycle.
- txn_count  output  CNT_W  number of accepted input transactions.

Behaviour:
- Reset (asynchronous, active-high): every register clears.
  - in_ready=1, out=0, out_sel=0, out_valid=0, txn_count=0, accumulator acc=0, both stage valids=0.
  - Asserting rst mid-operation drops all in-flight transactions; nothing is emitted for them after reset releases.
- Handshakes:
  - An input is accepted on a rising edge where in_valid && in_ready.
  - An output is consumed on a rising edge where out_valid && out_ready.
  - Inputs are sampled only on acceptance.
- Pipeline: two stages, S1 (operand register) and S2 (result register driving out, out_sel, out_valid).
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; there is no combinational path from in_valid.
  - Latency: a transaction accepted at edge k gives out_valid=1 after edge k+1 when there is no stall.
  - Throughput: one transaction per cycle.
- Stall:
  - While out_valid && !out_ready, S2 holds out and out_sel stable.
  - S1 holds if it is occupied.
  - in_ready drops only when both stages are full.
- Opcodes, evaluated when the transaction moves S1->S2. Arithmetic is zero-extended to DW+1.
  - 0: A+B. Bit DW is the carry.
  - 1: A-B computed as {0,A}-{0,B}. Bit DW=1 means borrow (e.g. 1-2 = 0x1_FFFF_FFFF).
  - 2: C+D.
  - 3: C-D, same rule as op 1.
  - 4: {0, A&B}.
  - 5: {0, C|D}.
  - 6: ACC_CLR. out={0,acc_old}; acc<=0.
  - 7: ACC_ADD. out={0,acc}+{0,A}; acc<=low DW bits of that sum, which wraps; bit DW of out is the carry.
- Accumulator ordering:
  - acc updates exactly once per op-6/7 transaction, on its S1->S2 edge.
  - Back-to-back accumulator ops see each other's result; there is no hazard bubble.
  - acc never updates during a stall.
- txn_count:
  - Increments by 1 on each accepted input.
  - Wraps from 2^CNT_W-1 to 0.
  - Counts acceptances, not outputs.
- Simultaneous consume and accept in the same cycle while full: both occur and the pipeline stays full.
- out_valid never deasserts without a consume or a reset.

Test Plan:
- Reset then a single op 0 with A=0xFFFF_FFFF, B=1 -> out=0x1_0000_0000 and out_sel=0; out_valid asserts on the 2nd edge after acceptance; txn_count=1.
- Op 1 with A=1, B=2, then op 3 with C=10, D=3, back-to-back with out_ready=1 -> outputs 0x1_FFFF_FFFF then 0x0_0000_0007 on consecutive cycles.
- Ops 7 (A=5), 7 (A=0xFFFF_FFFE), 6, 7 (A=3), back-to-back -> outputs 5, 0x1_0000_0003, 3, 3; final acc=3.
- Backpressure: 4 inputs issued with out_ready=0 -> in_ready drops after 2 accepts and out stays frozen at the first result; releasing out_ready drains all 4 results in order, none lost or duplicated.
- Ops 4 (A=0xF0F0_F0F0, B=0xFF00_FF00) and 5 (C=0x0000_00F0, D=0x0F00_0000) -> outputs 0x0_F000_F000 and 0x0_0F00_00F0.
- Assert rst while both stages are full and acc=7 -> out_valid=0, in_ready=1, txn_count=0 immediately; a following op 7 with A=1 returns 1.

Source files
------------

// File: rtl/mux_alu_core_if.sv
// Operand/result channel between a mux/ALU stimulus source (master) and mux_alu_core (slave).
interface mux_alu_core_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic [DW-1:0]    A;
    logic [DW-1:0]    B;
    logic [DW-1:0]    C;
    logic [DW-1:0]    D;
    logic [2:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [DW:0]      out;
    logic [2:0]       out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] txn_count;

    modport master (
        output A, B, C, D, sel, in_valid, out_ready,
        input  in_ready, out, out_sel, out_valid, txn_count
    );

    modport slave (
        input  A, B, C, D, sel, in_valid, out_ready,
        output in_ready, out, out_sel, out_valid, txn_count
    );
endinterface

// File: rtl/mux_alu_core.sv
// Two-stage 4-operand ALU/mux with running accumulator and valid/ready backpressure.
module mux_alu_core #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mux_alu_core_if.slave  bus
);
    logic [DW-1:0]    r_s1_a;
    logic [DW-1:0]    r_s1_b;
    logic [DW-1:0]    r_s1_c;
    logic [DW-1:0]    r_s1_d;
    logic [2:0]       r_s1_sel;
    logic             r_s1_valid;
    logic [DW:0]      r_out;
    logic [2:0]       r_out_sel;
    logic             r_out_valid;
    logic [DW-1:0]    r_acc;
    logic [CNT_W-1:0] r_txn_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_move;
    logic [DW:0]      w_result;
    logic [DW-1:0]    w_acc_next;

    assign w_s2_adv = !r_out_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = bus.in_valid && w_s1_adv;
    assign w_move   = r_s1_valid && w_s2_adv;

    assign bus.in_ready  = w_s1_adv;
    assign bus.out       = r_out;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.txn_count = r_txn_count;

    // Result and next accumulator both derive from the S1 contents, so
    // consecutive accumulator ops chain without a bubble.
    always_comb begin
        w_result   = '0;
        w_acc_next = r_acc;
        case (r_s1_sel)
            3'd0: w_result = {1'b0, r_s1_a} + {1'b0, r_s1_b};
            3'd1: w_result = {1'b0, r_s1_a} - {1'b0, r_s1_b};
            3'd2: w_result = {1'b0, r_s1_c} + {1'b0, r_s1_d};
            3'd3: w_result = {1'b0, r_s1_c} - {1'b0, r_s1_d};
            3'd4: w_result = {1'b0, r_s1_a & r_s1_b};
            3'd5: w_result = {1'b0, r_s1_c | r_s1_d};
            3'd6: begin
                w_result   = {1'b0, r_acc};
                w_acc_next = '0;
            end
            default: begin
                w_result   = {1'b0, r_acc} + {1'b0, r_s1_a};
                w_acc_next = w_result[DW-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_c      <= '0;
            r_s1_d      <= '0;
            r_s1_sel    <= '0;
            r_s1_valid  <= 1'b0;
            r_out       <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_txn_count <= '0;
        end else begin
            if (w_accept) begin
                r_s1_a      <= bus.A;
                r_s1_b      <= bus.B;
                r_s1_c      <= bus.C;
                r_s1_d      <= bus.D;
                r_s1_sel    <= bus.sel;
                r_txn_count <= r_txn_count + 1'b1;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_move) begin
                r_out     <= w_result;
                r_out_sel <= r_s1_sel;
                r_acc     <= w_acc_next;
            end
        end
    end
endmodule

// File: tb/tb_mux_alu_core.sv
// Directed self-checking bench for mux_alu_core: arithmetic, accumulator, backpressure, reset.
module tb_mux_alu_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_txn;

    mux_alu_core_if #(.DW(32), .CNT_W(16)) bus ();

    mux_alu_core #(.DW(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic v);
        bus.sel      = s;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.D        = d;
        bus.in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.out !== 33'h0) begin errors++; $display("FAIL reset_out got %h exp 0", bus.out); end
        checks++;
        if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL reset_out_sel got %0d exp 0", bus.out_sel); end
        checks++;
        if (bus.txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn got %0d exp 0", bus.txn_count); end
        rst = 1'b0;
        step();
        exp_txn = 0;
    endtask

    task automatic test_add_carry();
        drive(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1);
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", bus.out_valid); end
        step();
        exp_txn += 1;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
        checks++;
        if (bus.out !== 33'h1_0000_0000) begin errors++; $display("FAIL add_out got %h exp 100000000", bus.out); end
        checks++;
        if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL add_sel got %0d exp 0", bus.out_sel); end
        checks++;
        if (bus.txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL add_txn got %0d exp %0d", bus.txn_count, exp_txn); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back_sub();
        drive(3'd1, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1);
        step();
        drive(3'd3, 32'h0, 32'h0, 32'd10, 32'd3, 1'b1);
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 33'h1_FFFF_FFFF || bus.out_sel !== 3'd1) begin
            errors++; $display("FAIL sub_borrow got v=%b %h sel=%0d exp v=1 1ffffffff sel=1", bus.out_valid, bus.out, bus.out_sel);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 33'h0_0000_0007 || bus.out_sel !== 3'd3) begin
            errors++; $display("FAIL sub_cd got v=%b %h sel=%0d exp v=1 000000007 sel=3", bus.out_valid, bus.out, bus.out_sel);
        end
        step();
        exp_txn += 2;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sub_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_accumulator();
        logic [2:0]  sel_v [5];
        logic [31:0] a_v   [5];
        logic [32:0] exp_v [5];
        sel_v[0] = 3'd7; a_v[0] = 32'd5;          exp_v[0] = 33'h0_0000_0005;
        sel_v[1] = 3'd7; a_v[1] = 32'hFFFF_FFFE;  exp_v[1] = 33'h1_0000_0003;
        sel_v[2] = 3'd6; a_v[2] = 32'h1234_5678;  exp_v[2] = 33'h0_0000_0003;
        sel_v[3] = 3'd7; a_v[3] = 32'd3;          exp_v[3] = 33'h0_0000_0003;
        sel_v[4] = 3'd7; a_v[4] = 32'd0;          exp_v[4] = 33'h0_0000_0003;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(sel_v[i], a_v[i], 32'h0, 32'h0, 32'h0, 1'b1);
            else       drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
            step();
            if (i >= 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out !== exp_v[i-1] || bus.out_sel !== sel_v[i-1]) begin
                    errors++;
                    $display("FAIL acc_%0d got v=%b %h sel=%0d exp v=1 %h sel=%0d", i - 1,
                             bus.out_valid, bus.out, bus.out_sel, exp_v[i-1], sel_v[i-1]);
                end
            end
        end
        step();
        exp_txn += 5;
        checks++;
        if (bus.txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL acc_txn got %0d exp %0d", bus.txn_count, exp_txn); end
    endtask

    task automatic test_backpressure();
        int idx;
        int got;
        idx = 0;
        got = 0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            drive(3'd0, 32'(idx + 1), 32'h10, 32'h0, 32'h0, 1'b1);
            #1;
            if (bus.in_ready === 1'b1) idx++;
            step();
        end
        drive(3'd0, 32'(idx + 1), 32'h10, 32'h0, 32'h0, 1'b1);
        #1;
        checks++;
        if (idx != 2 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_fill got accepts=%0d in_ready=%b exp accepts=2 in_ready=0", idx, bus.in_ready);
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 33'h11 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b %h rdy=%b exp v=1 011 rdy=0", cyc, bus.out_valid, bus.out, bus.in_ready);
            end
        end
        checks++;
        if (bus.txn_count !== 16'(exp_txn + 2)) begin errors++; $display("FAIL bp_txn_stall got %0d exp %0d", bus.txn_count, exp_txn + 2); end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (idx < 4) drive(3'd0, 32'(idx + 1), 32'h10, 32'h0, 32'h0, 1'b1);
            else         drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
            #1;
            if (bus.in_valid && bus.in_ready === 1'b1) idx++;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out !== 33'(32'h11 + got)) begin
                    errors++; $display("FAIL bp_drain_%0d got %h exp %h", got, bus.out, 33'(32'h11 + got));
                end
                got++;
            end
            step();
        end
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        exp_txn += 4;
        checks++;
        if (got != 4 || idx != 4) begin errors++; $display("FAIL bp_count got out=%0d in=%0d exp out=4 in=4", got, idx); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got v=%b exp 0", bus.out_valid); end
        checks++;
        if (bus.txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL bp_txn got %0d exp %0d", bus.txn_count, exp_txn); end
    endtask

    task automatic test_logic_ops();
        drive(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 1'b1);
        step();
        drive(3'd5, 32'h0, 32'h0, 32'h0000_00F0, 32'h0F00_0000, 1'b1);
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.out !== 33'h0_F000_F000 || bus.out_sel !== 3'd4) begin
            errors++; $display("FAIL and_op got %h sel=%0d exp 0f000f000 sel=4", bus.out, bus.out_sel);
        end
        step();
        checks++;
        if (bus.out !== 33'h0_0F00_00F0 || bus.out_sel !== 3'd5) begin
            errors++; $display("FAIL or_op got %h sel=%0d exp 00f0000f0 sel=5", bus.out, bus.out_sel);
        end
        step();
        exp_txn += 2;
    endtask

    task automatic test_reset_midflight();
        drive(3'd7, 32'd4, 32'h0, 32'h0, 32'h0, 1'b1);
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (bus.out !== 33'h7) begin errors++; $display("FAIL acc_to_7 got %h exp 7", bus.out); end
        bus.out_ready = 1'b0;
        drive(3'd0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b1);
        step();
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_full got rdy=%b v=%b exp rdy=0 v=1", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.txn_count !== 16'd0) begin
            errors++; $display("FAIL rst_async got v=%b rdy=%b txn=%0d exp v=0 rdy=1 txn=0", bus.out_valid, bus.in_ready, bus.txn_count);
        end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost_%0d got v=%b exp 0", cyc, bus.out_valid); end
        end
        drive(3'd7, 32'd1, 32'h0, 32'h0, 32'h0, 1'b1);
        step();
        drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 33'h1 || bus.out_sel !== 3'd7) begin
            errors++; $display("FAIL rst_acc_cleared got v=%b %h sel=%0d exp v=1 1 sel=7", bus.out_valid, bus.out, bus.out_sel);
        end
        checks++;
        if (bus.txn_count !== 16'd1) begin errors++; $display("FAIL rst_txn got %0d exp 1", bus.txn_count); end
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_txn = 0;
        test_reset();
        test_add_carry();
        test_back_to_back_sub();
        test_accumulator();
        test_backpressure();
        test_logic_ops();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
